// File: rtl/fifo_bh_pkg.sv
// Shared widths and state encoding for the fifo_bh read-side drainer.
// Beat geometry is derived from the word and beat widths.
package fifo_bh_pkg;
  localparam int FIFO_DATA_WIDTH = 66;
  localparam int OUT_WIDTH       = 11;
  localparam int BEATS           = FIFO_DATA_WIDTH / OUT_WIDTH;
  localparam int BEAT_CNT_WIDTH  = $clog2(BEATS);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;
endpackage

// File: rtl/fifo_bh_drain_serializer.sv
// Pops FIFO words and serializes each LSB-first into OUT_WIDTH beats
// on a valid/ready stream, chaining the next pop onto the last beat.
module fifo_bh_drain_serializer
#(
  parameter int FIFO_DATA_WIDTH = fifo_bh_pkg::FIFO_DATA_WIDTH,
  parameter int OUT_WIDTH       = fifo_bh_pkg::OUT_WIDTH,
  parameter int BEATS           = fifo_bh_pkg::BEATS,
  parameter int BEAT_CNT_WIDTH  = fifo_bh_pkg::BEAT_CNT_WIDTH,
  parameter int WORD_CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       drain_en_i,
  input  logic                       fifo_empty_i,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                       fifo_rden_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [OUT_WIDTH-1:0]       out_data_o,
  output logic                       out_last_o,
  output logic                       busy_o,
  output logic [WORD_CNT_WIDTH-1:0]  word_count_o
);
  import fifo_bh_pkg::ST_IDLE;
  import fifo_bh_pkg::ST_SEND;

  localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT =
    BEAT_CNT_WIDTH'(BEATS - 1);

  logic [0:0]                 r_state;
  logic [FIFO_DATA_WIDTH-1:0] r_shreg;
  logic [BEAT_CNT_WIDTH-1:0]  r_beat;
  logic [WORD_CNT_WIDTH-1:0]  r_wcnt;

  logic w_send;
  logic w_last;
  logic w_xfer;
  logic w_load;

  assign w_send = (r_state == ST_SEND);
  assign w_last = (r_beat == LAST_BEAT);
  assign w_xfer = w_send & out_ready_i;

  // Empty guard lives here: the FIFO itself does not block underflow.
  assign w_load = ~reset & drain_en_i & ~fifo_empty_i &
                  (~w_send | (w_xfer & w_last));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_beat  <= '0;
      r_wcnt  <= '0;
    end else begin
      if (w_load) begin
        r_state <= ST_SEND;
        r_shreg <= fifo_rdata_i;
        r_beat  <= '0;
      end else if (w_xfer) begin
        r_shreg <= r_shreg >> OUT_WIDTH;
        if (w_last) begin
          r_state <= ST_IDLE;
          r_beat  <= '0;
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
      if (w_xfer & w_last)
        r_wcnt <= r_wcnt + 1'b1;
    end
  end

  assign fifo_rden_o  = w_load;
  assign out_valid_o  = w_send;
  assign busy_o       = w_send;
  assign out_data_o   = r_shreg[OUT_WIDTH-1:0];
  assign out_last_o   = w_send & w_last;
  assign word_count_o = r_wcnt;
endmodule

// File: tb/tb_fifo_bh_drain_serializer.sv
// Randomized and directed bench for fifo_bh_drain_serializer with a
// queue-based FIFO and a word/beat-index reference model.
module tb_fifo_bh_drain_serializer;
  localparam int W  = 66;
  localparam int OW = 11;
  localparam int NB = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          drain_en_i = 1'b0;
  logic          fifo_empty_i = 1'b1;
  logic [W-1:0]  fifo_rdata_i = '0;
  logic          out_ready_i = 1'b0;
  logic          fifo_rden_o;
  logic          out_valid_o;
  logic [OW-1:0] out_data_o;
  logic          out_last_o;
  logic          busy_o;
  logic [15:0]   word_count_o;

  fifo_bh_drain_serializer dut (
    .clk          (clk),
    .reset        (reset),
    .drain_en_i   (drain_en_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_rden_o  (fifo_rden_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_last_o   (out_last_o),
    .busy_o       (busy_o),
    .word_count_o (word_count_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int pops = 0;

  logic [W-1:0]  fq[$];
  logic [OW-1:0] acc_q[$];
  int            rden_cyc[$];
  int            vcyc[$];

  logic [W-1:0]  m_word = '0;
  int            m_idx = -1;
  logic [15:0]   m_cnt = '0;

  logic          p_stall = 1'b0;
  logic [OW-1:0] p_data = '0;
  logic          p_last = 1'b0;

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic cyc();
    logic          e_valid;
    logic          e_last;
    logic          e_rden;
    logic [OW-1:0] e_data;
    fifo_empty_i = (fq.size() == 0);
    fifo_rdata_i = (fq.size() != 0) ? fq[0] : '0;
    @(negedge clk);
    e_valid = (m_idx >= 0);
    e_last  = e_valid && (m_idx == NB - 1);
    e_data  = e_valid ? m_word[m_idx*OW +: OW] : '0;
    e_rden  = !reset && drain_en_i && !fifo_empty_i &&
              (!e_valid || (out_ready_i && e_last));
    chk("valid", W'(out_valid_o), W'(e_valid));
    chk("busy", W'(busy_o), W'(e_valid));
    chk("last", W'(out_last_o), W'(e_last));
    chk("rden", W'(fifo_rden_o), W'(e_rden));
    chk("wcnt", W'(word_count_o), W'(m_cnt));
    chk("underflow", W'(fifo_rden_o & fifo_empty_i), '0);
    if (e_valid) chk("data", W'(out_data_o), W'(e_data));
    if (p_stall) begin
      chk("stall_data", W'(out_data_o), W'(p_data));
      chk("stall_last", W'(out_last_o), W'(p_last));
    end
    p_stall = out_valid_o && !out_ready_i && !reset;
    p_data  = out_data_o;
    p_last  = out_last_o;
    if (out_valid_o && out_ready_i && !reset) acc_q.push_back(out_data_o);
    if (out_valid_o) vcyc.push_back(cyc_n);
    if (fifo_rden_o) begin
      pops++;
      rden_cyc.push_back(cyc_n);
    end
    @(posedge clk);
    if (reset) begin
      m_idx = -1;
      m_cnt = '0;
    end else begin
      if (e_valid && out_ready_i && e_last) m_cnt = m_cnt + 16'd1;
      if (e_rden) begin
        m_word = fifo_rdata_i;
        m_idx  = 0;
      end else if (e_valid && out_ready_i) begin
        m_idx = e_last ? -1 : m_idx + 1;
      end
    end
    if (e_rden) void'(fq.pop_front());
    cyc_n++;
    #1;
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    acc_q.delete();
    rden_cyc.delete();
    vcyc.delete();
    pops = 0;
  endtask

  task automatic rand_word(output logic [W-1:0] w);
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    w = t[W-1:0];
  endtask

  initial begin
    logic [OW-1:0] lit[NB];
    logic [W-1:0]  w;
    logic [W-1:0]  sh;
    int            base;
    lit = '{11'h5EF, 11'h579, 11'h626, 11'h2B3, 11'h234, 11'h402};

    reset = 1'b1;
    cyc();
    cyc();
    chk("rst_valid", W'(out_valid_o), '0);
    chk("rst_data", W'(out_data_o), '0);
    chk("rst_last", W'(out_last_o), '0);
    chk("rst_busy", W'(busy_o), '0);
    chk("rst_wcnt", W'(word_count_o), '0);
    chk("rst_rden", W'(fifo_rden_o), '0);
    do_reset();

    // single word, known slices
    fq.push_back(66'h2_0123_4567_89AB_CDEF);
    drain_en_i  = 1'b1;
    out_ready_i = 1'b1;
    run(10);
    chk("t1_pops", W'(pops), W'(1));
    chk("t1_nbeats", W'(acc_q.size()), W'(NB));
    for (int i = 0; i < NB; i++)
      chk("t1_beat", (i < acc_q.size()) ? W'(acc_q[i]) : 'x, W'(lit[i]));
    chk("t1_wcnt", W'(word_count_o), W'(1));
    chk("t1_idle", W'(busy_o), '0);

    // three words back to back
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rand_word(w);
      fq.push_back(w);
    end
    base = cyc_n;
    run(22);
    chk("t2_npop", W'(rden_cyc.size()), W'(3));
    for (int i = 0; i < 3; i++)
      chk("t2_popcyc", (i < rden_cyc.size()) ? W'(rden_cyc[i] - base) : 'x,
          W'(6 * i));
    chk("t2_nvalid", W'(vcyc.size()), W'(18));
    if (vcyc.size() == 18)
      chk("t2_nobubble", W'(vcyc[17] - vcyc[0]), W'(17));
    chk("t2_empty", W'(fq.size()), '0);
    chk("t2_wcnt", W'(word_count_o), W'(3));

    // backpressure pattern 1,0,0,1
    do_reset();
    rand_word(w);
    fq.push_back(w);
    for (int i = 0; i < 30; i++) begin
      out_ready_i = (i % 4 == 0) || (i % 4 == 3);
      cyc();
    end
    chk("t3_nbeats", W'(acc_q.size()), W'(NB));
    sh = w;
    for (int i = 0; i < NB; i++) begin
      chk("t3_beat", (i < acc_q.size()) ? W'(acc_q[i]) : 'x, W'(sh[OW-1:0]));
      sh = sh >> OW;
    end
    chk("t3_pops", W'(pops), W'(1));

    // empty FIFO with drain enabled
    do_reset();
    out_ready_i = 1'b1;
    run(10);
    chk("t4_pops", W'(pops), '0);
    chk("t4_nvalid", W'(vcyc.size()), '0);

    // enable dropped at beat 2
    do_reset();
    for (int i = 0; i < 2; i++) begin
      rand_word(w);
      fq.push_back(w);
    end
    run(3);
    drain_en_i = 1'b0;
    run(10);
    chk("t5_busy", W'(busy_o), '0);
    chk("t5_fifo", W'(fq.size()), W'(1));
    chk("t5_wcnt", W'(word_count_o), W'(1));
    drain_en_i = 1'b1;
    run(10);
    chk("t5_fifo2", W'(fq.size()), '0);
    chk("t5_wcnt2", W'(word_count_o), W'(2));

    // reset mid-word at beat 3
    do_reset();
    rand_word(w);
    fq.push_back(w);
    run(4);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t6_valid", W'(out_valid_o), '0);
    chk("t6_data", W'(out_data_o), '0);
    chk("t6_last", W'(out_last_o), '0);
    chk("t6_busy", W'(busy_o), '0);
    chk("t6_wcnt", W'(word_count_o), '0);
    chk("t6_fifo", W'(fq.size()), '0);
    run(3);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0 && fq.size() < 8) begin
        rand_word(w);
        fq.push_back(w);
      end
      drain_en_i  = ($urandom_range(0, 7) != 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
